// File: rtl/hazard_unit_mc_if.sv
// Pipeline hazard bus: datapath stage fields in, stall/flush/forward controls and MDU status out.
// master = datapath side, slave = hazard controller.
interface hazard_unit_mc_if #(
    parameter int AW     = 5,
    parameter int PERF_W = 32
);
    logic              branch_d;
    logic              jr_d;
    logic              jump_d;
    logic              pcsrc_d;
    logic              use_rs_d;
    logic              use_rt_d;
    logic [AW-1:0]     rs_d;
    logic [AW-1:0]     rt_d;
    logic [AW-1:0]     rs_e;
    logic [AW-1:0]     rt_e;
    logic              memread_e;
    logic              regwrite_e;
    logic [AW-1:0]     writereg_e;
    logic              memread_m;
    logic              regwrite_m;
    logic [AW-1:0]     writereg_m;
    logic              regwrite_w;
    logic [AW-1:0]     writereg_w;
    logic              mdu_start_e;
    logic              mdu_use_d;

    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [1:0]        forward_ae;
    logic [1:0]        forward_be;
    logic [1:0]        forward_ad;
    logic [1:0]        forward_bd;
    logic              mdu_busy;
    logic              mdu_done;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output branch_d, jr_d, jump_d, pcsrc_d, use_rs_d, use_rt_d,
        output rs_d, rt_d, rs_e, rt_e,
        output memread_e, regwrite_e, writereg_e,
        output memread_m, regwrite_m, writereg_m,
        output regwrite_w, writereg_w,
        output mdu_start_e, mdu_use_d,
        input  stall_f, stall_d, flush_d, flush_e,
        input  forward_ae, forward_be, forward_ad, forward_bd,
        input  mdu_busy, mdu_done, stall_cycles
    );

    modport slave (
        input  branch_d, jr_d, jump_d, pcsrc_d, use_rs_d, use_rt_d,
        input  rs_d, rt_d, rs_e, rt_e,
        input  memread_e, regwrite_e, writereg_e,
        input  memread_m, regwrite_m, writereg_m,
        input  regwrite_w, writereg_w,
        input  mdu_start_e, mdu_use_d,
        output stall_f, stall_d, flush_d, flush_e,
        output forward_ae, forward_be, forward_ad, forward_bd,
        output mdu_busy, mdu_done, stall_cycles
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// 5-stage MIPS hazard/forwarding controller with MDU busy interlock and stall-cycle counter.
// Latency: controls are combinational, MDU/perf state updates each edge; backpressure: stall_f/stall_d hold IF/ID.
module hazard_unit_mc #(
    parameter int AW            = 5,
    parameter int MDU_CYCLES    = 32,
    parameter int WB_BRANCH_FWD = 1,
    parameter int PERF_W        = 32
) (
    input  logic           clk,
    input  logic           rst,
    hazard_unit_mc_if.slave hz
);
    localparam int CW = $clog2(MDU_CYCLES + 1);

    function automatic logic hit(input logic we, input logic [AW-1:0] wa, input logic [AW-1:0] ra);
        return we && (wa != '0) && (wa == ra);
    endfunction

    function automatic logic [1:0] fwd_ex(input logic [AW-1:0] ra);
        if (hit(hz.regwrite_m, hz.writereg_m, ra))      return 2'b10;
        else if (hit(hz.regwrite_w, hz.writereg_w, ra)) return 2'b01;
        else                                             return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_id(input logic [AW-1:0] ra);
        if (hit(hz.regwrite_m, hz.writereg_m, ra))                             return 2'b10;
        else if ((WB_BRANCH_FWD != 0) && hit(hz.regwrite_w, hz.writereg_w, ra)) return 2'b01;
        else                                                                    return 2'b00;
    endfunction

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rsu, rtu;
    logic lwstall, branchstall, mdu_stall, stall;

    always_comb begin
        rsu = hz.use_rs_d | hz.branch_d | hz.jr_d;
        rtu = hz.use_rt_d | hz.branch_d;

        lwstall = hz.memread_e &
                  ((rsu & hit(1'b1, hz.writereg_e, hz.rs_d)) |
                   (rtu & hit(1'b1, hz.writereg_e, hz.rt_d)));

        // A branch/jr compares in ID, so an ALU result still in EX or a load still in MEM is not yet forwardable.
        branchstall = ((hz.branch_d | hz.jr_d) &
                       (hit(hz.regwrite_e, hz.writereg_e, hz.rs_d) |
                        hit(hz.memread_m,  hz.writereg_m, hz.rs_d))) |
                      (hz.branch_d &
                       (hit(hz.regwrite_e, hz.writereg_e, hz.rt_d) |
                        hit(hz.memread_m,  hz.writereg_m, hz.rt_d)));

        mdu_stall = ~rst & hz.mdu_use_d & (busy_q | hz.mdu_start_e);
        stall     = lwstall | branchstall | mdu_stall;
    end

    assign hz.stall_f      = stall;
    assign hz.stall_d      = stall;
    assign hz.flush_e      = stall;
    assign hz.flush_d      = (hz.pcsrc_d | hz.jump_d | hz.jr_d) & ~stall;
    assign hz.forward_ae   = fwd_ex(hz.rs_e);
    assign hz.forward_be   = fwd_ex(hz.rt_e);
    assign hz.forward_ad   = fwd_id(hz.rs_d);
    assign hz.forward_bd   = fwd_id(hz.rt_d);
    assign hz.mdu_busy     = busy_q;
    assign hz.mdu_done     = busy_q && (cnt_q == CW'(1));
    assign hz.stall_cycles = stall_cnt_q;

    always_comb begin
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        stall_cnt_d = stall_cnt_q;

        // A start arriving while busy is illegal upstream and deliberately ignored here (no reload).
        if (busy_q) begin
            cnt_d  = cnt_q - CW'(1);
            busy_d = (cnt_q != CW'(1));
        end else if (hz.mdu_start_e) begin
            cnt_d  = CW'(MDU_CYCLES);
            busy_d = 1'b1;
        end

        if (stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed + random bench for hazard_unit_mc; two instances differ in WB branch forwarding and counter width.
module tb_hazard_unit_mc;
    localparam int AW  = 5;
    localparam int MDU = 4;

    logic clk, rst;
    logic branch_d, jr_d, jump_d, pcsrc_d, use_rs_d, use_rt_d;
    logic memread_e, regwrite_e, memread_m, regwrite_m, regwrite_w;
    logic mdu_start_e, mdu_use_d;
    logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;

    hazard_unit_mc_if #(.AW(AW), .PERF_W(3))  ifa ();
    hazard_unit_mc_if #(.AW(AW), .PERF_W(32)) ifb ();

    hazard_unit_mc #(.AW(AW), .MDU_CYCLES(MDU), .WB_BRANCH_FWD(1), .PERF_W(3))
        dut_a (.clk(clk), .rst(rst), .hz(ifa));
    hazard_unit_mc #(.AW(AW), .MDU_CYCLES(MDU), .WB_BRANCH_FWD(0), .PERF_W(32))
        dut_b (.clk(clk), .rst(rst), .hz(ifb));

    assign ifa.branch_d = branch_d;       assign ifb.branch_d = branch_d;
    assign ifa.jr_d = jr_d;               assign ifb.jr_d = jr_d;
    assign ifa.jump_d = jump_d;           assign ifb.jump_d = jump_d;
    assign ifa.pcsrc_d = pcsrc_d;         assign ifb.pcsrc_d = pcsrc_d;
    assign ifa.use_rs_d = use_rs_d;       assign ifb.use_rs_d = use_rs_d;
    assign ifa.use_rt_d = use_rt_d;       assign ifb.use_rt_d = use_rt_d;
    assign ifa.rs_d = rs_d;               assign ifb.rs_d = rs_d;
    assign ifa.rt_d = rt_d;               assign ifb.rt_d = rt_d;
    assign ifa.rs_e = rs_e;               assign ifb.rs_e = rs_e;
    assign ifa.rt_e = rt_e;               assign ifb.rt_e = rt_e;
    assign ifa.memread_e = memread_e;     assign ifb.memread_e = memread_e;
    assign ifa.regwrite_e = regwrite_e;   assign ifb.regwrite_e = regwrite_e;
    assign ifa.writereg_e = writereg_e;   assign ifb.writereg_e = writereg_e;
    assign ifa.memread_m = memread_m;     assign ifb.memread_m = memread_m;
    assign ifa.regwrite_m = regwrite_m;   assign ifb.regwrite_m = regwrite_m;
    assign ifa.writereg_m = writereg_m;   assign ifb.writereg_m = writereg_m;
    assign ifa.regwrite_w = regwrite_w;   assign ifb.regwrite_w = regwrite_w;
    assign ifa.writereg_w = writereg_w;   assign ifb.writereg_w = writereg_w;
    assign ifa.mdu_start_e = mdu_start_e; assign ifb.mdu_start_e = mdu_start_e;
    assign ifa.mdu_use_d = mdu_use_d;     assign ifb.mdu_use_d = mdu_use_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: cycle index and the cycle in which the MDU last issued.
    int    cyc = 0;
    int    issue_cyc = -1;
    longint cnt_a = 0, cnt_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input bit we, input int wa, input int ra);
        return we && wa != 0 && wa == ra;
    endfunction

    function automatic int fwd_e(input int ra);
        if (hit(regwrite_m, writereg_m, ra)) return 2;
        if (hit(regwrite_w, writereg_w, ra)) return 1;
        return 0;
    endfunction

    function automatic int fwd_d(input int ra, input bit wbf);
        if (hit(regwrite_m, writereg_m, ra)) return 2;
        if (wbf && hit(regwrite_w, writereg_w, ra)) return 1;
        return 0;
    endfunction

    function automatic bit m_busy();
        return issue_cyc >= 0 && cyc > issue_cyc && cyc <= issue_cyc + MDU;
    endfunction

    function automatic bit m_done();
        return m_busy() && cyc == issue_cyc + MDU;
    endfunction

    function automatic bit m_stall();
        bit rs_used, rt_used, lw, br, md;
        rs_used = use_rs_d || branch_d || jr_d;
        rt_used = use_rt_d || branch_d;
        lw = memread_e && ((rs_used && hit(1, writereg_e, rs_d)) || (rt_used && hit(1, writereg_e, rt_d)));
        br = ((branch_d || jr_d) && (hit(regwrite_e, writereg_e, rs_d) || hit(memread_m, writereg_m, rs_d))) ||
             (branch_d && (hit(regwrite_e, writereg_e, rt_d) || hit(memread_m, writereg_m, rt_d)));
        md = !rst && mdu_use_d && (m_busy() || mdu_start_e);
        return lw || br || md;
    endfunction

    // Compare every output of both instances to the model, then advance one clock.
    task automatic tick();
        bit s, fl;
        @(negedge clk);
        s  = m_stall();
        fl = (pcsrc_d || jump_d || jr_d) && !s;
        chk("a_stall_f", 32'(ifa.stall_f), 32'(s));
        chk("a_stall_d", 32'(ifa.stall_d), 32'(s));
        chk("a_flush_e", 32'(ifa.flush_e), 32'(s));
        chk("a_flush_d", 32'(ifa.flush_d), 32'(fl));
        chk("a_fwd_ae", 32'(ifa.forward_ae), 32'(fwd_e(rs_e)));
        chk("a_fwd_be", 32'(ifa.forward_be), 32'(fwd_e(rt_e)));
        chk("a_fwd_ad", 32'(ifa.forward_ad), 32'(fwd_d(rs_d, 1)));
        chk("a_fwd_bd", 32'(ifa.forward_bd), 32'(fwd_d(rt_d, 1)));
        chk("a_busy", 32'(ifa.mdu_busy), 32'(m_busy()));
        chk("a_done", 32'(ifa.mdu_done), 32'(m_done()));
        chk("a_stall_cycles", 32'(ifa.stall_cycles), 32'(cnt_a));
        chk("b_stall_f", 32'(ifb.stall_f), 32'(s));
        chk("b_flush_d", 32'(ifb.flush_d), 32'(fl));
        chk("b_fwd_ae", 32'(ifb.forward_ae), 32'(fwd_e(rs_e)));
        chk("b_fwd_be", 32'(ifb.forward_be), 32'(fwd_e(rt_e)));
        chk("b_fwd_ad", 32'(ifb.forward_ad), 32'(fwd_d(rs_d, 0)));
        chk("b_fwd_bd", 32'(ifb.forward_bd), 32'(fwd_d(rt_d, 0)));
        chk("b_busy", 32'(ifb.mdu_busy), 32'(m_busy()));
        chk("b_done", 32'(ifb.mdu_done), 32'(m_done()));
        chk("b_stall_cycles", ifb.stall_cycles, 32'(cnt_b));
        chk("start_while_busy", 32'(mdu_start_e & ifa.mdu_busy), 32'(0));
        @(posedge clk);
        if (rst) begin
            issue_cyc = -1;
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (s) begin
                if (cnt_a < 7) cnt_a++;
                if (cnt_b < 64'hFFFF_FFFF) cnt_b++;
            end
            if (mdu_start_e && !m_busy()) issue_cyc = cyc;
        end
        cyc++;
        #1;
    endtask

    task automatic clear();
        branch_d = 0; jr_d = 0; jump_d = 0; pcsrc_d = 0; use_rs_d = 0; use_rt_d = 0;
        memread_e = 0; regwrite_e = 0; memread_m = 0; regwrite_m = 0; regwrite_w = 0;
        mdu_start_e = 0; mdu_use_d = 0;
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; writereg_e = 0; writereg_m = 0; writereg_w = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        clear();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #2;
        chk("reset_busy", 32'(ifa.mdu_busy), 32'(0));
        chk("reset_done", 32'(ifa.mdu_done), 32'(0));
        chk("reset_stall_cycles", 32'(ifb.stall_cycles), 32'(0));

        // EX forwarding: MEM beats WB; register 0 never forwards
        regwrite_m = 1; writereg_m = 8; regwrite_w = 1; writereg_w = 8; rs_e = 8;
        #2 chk("ex_fwd_mem", 32'(ifa.forward_ae), 32'(2));
        tick();
        regwrite_m = 0;
        #2 chk("ex_fwd_wb", 32'(ifa.forward_ae), 32'(1));
        tick();
        regwrite_m = 1; writereg_m = 0; writereg_w = 0; rs_e = 0;
        #2 chk("ex_fwd_r0", 32'(ifa.forward_ae), 32'(0));
        tick();

        // Load-use: one stall, then bubble clears it; unused rt does not stall
        clear();
        memread_e = 1; writereg_e = 9; rt_d = 9; use_rt_d = 1;
        #2 chk("lw_stall", 32'({ifa.stall_f, ifa.stall_d, ifa.flush_e}), 32'(7));
        tick();
        memread_e = 0;
        #2 chk("lw_stall_gone", 32'(ifa.stall_f), 32'(0));
        tick();
        memread_e = 1; use_rt_d = 0;
        #2 chk("lw_no_use", 32'(ifa.stall_f), 32'(0));
        tick();

        // Branch on ALU result in EX, then forwarded from MEM
        clear();
        branch_d = 1; rs_d = 10; regwrite_e = 1; writereg_e = 10; pcsrc_d = 1;
        #2 chk("br_stall", 32'({ifa.stall_f, ifa.flush_d}), 32'(2));
        tick();
        regwrite_e = 0; regwrite_m = 1; writereg_m = 10;
        #2 chk("br_fwd_mem", 32'({ifa.forward_ad, ifa.stall_f, ifa.flush_d}), 32'(4'b1001));
        tick();
        memread_m = 1;
        #2 chk("br_load_in_mem", 32'({ifa.stall_f, ifa.flush_d}), 32'(2));
        tick();
        clear();
        jr_d = 1; rs_d = 10; regwrite_e = 1; writereg_e = 10;
        #2 chk("jr_stall", 32'({ifa.stall_f, ifa.flush_d}), 32'(2));
        tick();

        // ID compare from WB depends on WB_BRANCH_FWD
        clear();
        regwrite_w = 1; writereg_w = 10; rs_d = 10; branch_d = 1;
        #2 chk("id_wb_fwd_on", 32'(ifa.forward_ad), 32'(1));
        chk("id_wb_fwd_off", 32'(ifb.forward_ad), 32'(0));
        tick();

        // MDU interlock: issue + 4 busy cycles stall, done on the last busy cycle
        clear();
        do_reset();
        mdu_start_e = 1; mdu_use_d = 1;
        #2 chk("mdu_issue_stall", 32'(ifa.stall_f), 32'(1));
        tick();
        mdu_start_e = 0;
        for (int i = 1; i <= MDU; i++) begin
            #2 chk("mdu_busy_cycle", 32'({ifa.mdu_busy, ifa.mdu_done, ifa.stall_f}), 32'({1'b1, i == MDU, 1'b1}));
            tick();
        end
        #2 chk("mdu_idle", 32'({ifa.mdu_busy, ifa.stall_f}), 32'(0));
        chk("mdu_stall_cycles_a", 32'(ifa.stall_cycles), 32'(5));
        chk("mdu_stall_cycles_b", ifb.stall_cycles, 32'(5));
        tick();

        // Reset during busy cycle 2 aborts the operation
        mdu_start_e = 1;
        tick();
        mdu_start_e = 0;
        tick();
        rst = 1;
        #2 chk("mdu_rst_cycle", 32'({ifa.mdu_busy, ifa.stall_f}), 32'(2));
        tick();
        rst = 0;
        #2 chk("mdu_after_rst", 32'({ifa.mdu_busy, ifa.stall_f}), 32'(0));
        tick();

        // Saturation of the 3-bit counter
        clear();
        do_reset();
        memread_e = 1; writereg_e = 9; rs_d = 9; use_rs_d = 1;
        repeat (9) tick();
        #2 chk("perf_sat_a", 32'(ifa.stall_cycles), 32'(7));
        chk("perf_nosat_b", ifb.stall_cycles, 32'(9));
        tick();

        // Random traffic against the model
        clear();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            branch_d   = ($urandom_range(0, 3) == 0);
            jr_d       = !branch_d && ($urandom_range(0, 5) == 0);
            jump_d     = ($urandom_range(0, 7) == 0);
            pcsrc_d    = 1'($urandom_range(0, 1));
            use_rs_d   = 1'($urandom_range(0, 1));
            use_rt_d   = 1'($urandom_range(0, 1));
            memread_e  = 1'($urandom_range(0, 1));
            regwrite_e = 1'($urandom_range(0, 1));
            memread_m  = 1'($urandom_range(0, 1));
            regwrite_m = 1'($urandom_range(0, 1));
            regwrite_w = 1'($urandom_range(0, 1));
            rs_d = AW'($urandom_range(0, 3));       rt_d = AW'($urandom_range(0, 3));
            rs_e = AW'($urandom_range(0, 3));       rt_e = AW'($urandom_range(0, 3));
            writereg_e = AW'($urandom_range(0, 3)); writereg_m = AW'($urandom_range(0, 3));
            writereg_w = AW'($urandom_range(0, 3));
            mdu_use_d   = ($urandom_range(0, 2) == 0);
            mdu_start_e = !m_busy() && ($urandom_range(0, 5) == 0);
            tick();
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
